// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: merges pipeline writeback (fixed priority) with
// buffered multdiv results, and tracks which registers still await a multdiv write.
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                clock,
    input  logic                ctrl_reset,
    input  logic                wb_valid,
    input  logic [4:0]          wb_reg,
    input  logic [31:0]         wb_data,
    input  logic                md_issue,
    input  logic [4:0]          md_issue_reg,
    input  logic                md_valid,
    input  logic [4:0]          md_reg,
    input  logic [31:0]         md_data,
    output logic                md_ready,
    output logic                ctrl_writeEnable,
    output logic [4:0]          ctrl_writeReg,
    output logic [31:0]         data_writeReg,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [1:0]          fifo_count
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              ENTRIES  = 1 << PW;
    localparam logic [1:0]      DEPTH_C  = 2'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);

    logic [4:0]          fifo_reg  [ENTRIES];
    logic [31:0]         fifo_data [ENTRIES];
    logic [PW-1:0]       head, tail;
    logic [1:0]          count;
    logic [NUM_REGS-1:0] pending;

    logic                md_accept;
    logic                fifo_empty;
    logic                sel_valid;
    logic                sel_from_md;
    logic [4:0]          sel_reg;
    logic [31:0]         sel_data;
    logic                enq;
    logic                deq;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Handshake: a multdiv result transfers on a cycle where md_valid && md_ready;
    // md_ready depends only on FIFO occupancy, and the source holds md_reg/md_data
    // stable until the transfer happens.
    assign md_ready   = (count < DEPTH_C);
    assign md_accept  = md_valid && md_ready;
    assign fifo_empty = (count == 2'd0);

    always_comb begin
        sel_valid   = 1'b0;
        sel_from_md = 1'b0;
        sel_reg     = '0;
        sel_data    = '0;
        enq         = 1'b0;
        deq         = 1'b0;
        if (wb_valid) begin
            sel_valid = 1'b1;
            sel_reg   = wb_reg;
            sel_data  = wb_data;
            enq       = md_accept;
        end else if (!fifo_empty) begin
            sel_valid   = 1'b1;
            sel_from_md = 1'b1;
            sel_reg     = fifo_reg[head];
            sel_data    = fifo_data[head];
            deq         = 1'b1;
            enq         = md_accept;
        end else if (md_accept) begin
            sel_valid   = 1'b1;
            sel_from_md = 1'b1;
            sel_reg     = md_reg;
            sel_data    = md_data;
        end
    end

    // A clear and a set to the same register in one cycle leave the bit set.
    assign clr_mask = (sel_from_md && sel_reg != 5'd0) ? (ONE << sel_reg) : '0;
    assign set_mask = (md_issue && md_issue_reg != 5'd0) ? (ONE << md_issue_reg) : '0;

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            pending          <= '0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                fifo_reg[i]  <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                fifo_reg[tail]  <= md_reg;
                fifo_data[tail] <= md_data;
                tail            <= next_ptr(tail);
            end
            if (deq) begin
                head <= next_ptr(head);
            end
            count   <= count + 2'(enq) - 2'(deq);
            pending <= (pending & ~clr_mask) | set_mask;
            // Register 0 writes are consumed but never reach the regfile.
            ctrl_writeEnable <= sel_valid && (sel_reg != 5'd0);
            if (sel_valid && sel_reg != 5'd0) begin
                ctrl_writeReg <= sel_reg;
                data_writeReg <= sel_data;
            end
        end
    end

    assign pending_mask = pending;
    assign fifo_count   = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the write port.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;
    logic [1:0]  fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [36:0] exp_q[$];
    logic [31:0] exp_pending;
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    logic        exp_acc;

    regfile_write_arbiter #(.DEPTH(DEPTH), .NUM_REGS(32)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_issue         (md_issue),
        .md_issue_reg     (md_issue_reg),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending_mask     (pending_mask),
        .fifo_count       (fifo_count)
    );

    always #5 clock = ~clock;

    // Reference model: one rising edge of the write port, from the current inputs.
    task automatic model_step();
        logic [36:0] w;
        logic        have_w;
        logic        md_src;
        logic        acc;
        exp_acc = 1'b0;
        if (!ctrl_reset) begin
            exp_q.delete();
            exp_pending = '0;
            exp_we      = 1'b0;
            exp_reg     = '0;
            exp_data    = '0;
            return;
        end
        acc     = md_valid && (exp_q.size() < DEPTH);
        exp_acc = acc;
        have_w  = 1'b1;
        md_src  = 1'b0;
        w       = '0;
        if (wb_valid) begin
            w = {wb_reg, wb_data};
        end else if (exp_q.size() > 0) begin
            w      = exp_q.pop_front();
            md_src = 1'b1;
        end else if (acc) begin
            w      = {md_reg, md_data};
            md_src = 1'b1;
            acc    = 1'b0;
        end else begin
            have_w = 1'b0;
        end
        if (acc) exp_q.push_back({md_reg, md_data});
        exp_we = have_w && (w[36:32] != 5'd0);
        if (exp_we) begin
            exp_reg  = w[36:32];
            exp_data = w[31:0];
            if (md_src) exp_pending[w[36:32]] = 1'b0;
        end
        if (md_issue && md_issue_reg != 5'd0) exp_pending[md_issue_reg] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        ctrl_reset   = 1'b1;
        wb_valid     = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        md_issue     = 1'b0;
        md_issue_reg = '0;
        md_valid     = 1'b0;
        md_reg       = '0;
        md_data      = '0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wb_valid     = 1'($urandom_range(0, 1));
            wb_reg       = 5'($urandom_range(0, 31));
            wb_data      = $urandom;
            md_issue     = 1'($urandom_range(0, 1));
            md_issue_reg = 5'($urandom_range(0, 31));
            md_valid     = 1'($urandom_range(0, 1));
            md_reg       = 5'($urandom_range(0, 31));
            md_data      = $urandom;
            tick();
        end
        tests_run++;
        if (ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %0b expected 0", ctrl_writeEnable); end
        tests_run++;
        if (ctrl_writeReg !== 5'd0) begin tests_failed++; $display("FAIL reset_reg: got %0d expected 0", ctrl_writeReg); end
        tests_run++;
        if (data_writeReg !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %08h expected 0", data_writeReg); end
        tests_run++;
        if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL reset_pending: got %08h expected 0", pending_mask); end
        tests_run++;
        if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        tests_run++;
        if (md_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 1", md_ready); end
        set_idle();
    endtask

    task automatic test_pipeline_write();
        wb_valid = 1'b1;
        wb_reg   = 5'd5;
        wb_data  = 32'hDEADBEEF;
        tick();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1) begin tests_failed++; $display("FAIL wb_we: got %0b expected 1", ctrl_writeEnable); end
        tests_run++;
        if (ctrl_writeReg !== 5'd5) begin tests_failed++; $display("FAIL wb_reg: got %0d expected 5", ctrl_writeReg); end
        tests_run++;
        if (data_writeReg !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wb_data: got %08h expected deadbeef", data_writeReg); end
        wb_reg  = 5'd0;
        wb_data = 32'h0000_0123;
        tick();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL wb_reg0_we: got %0b expected 0", ctrl_writeEnable); end
        set_idle();
        tick();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0) begin tests_failed++; $display("FAIL idle_we: got %0b expected 0", ctrl_writeEnable); end
    endtask

    task automatic test_bypass();
        md_issue     = 1'b1;
        md_issue_reg = 5'd7;
        tick();
        md_issue = 1'b0;
        tests_run++;
        if (pending_mask !== 32'h0000_0080) begin tests_failed++; $display("FAIL byp_pending_set: got %08h expected 00000080", pending_mask); end
        tick();
        md_valid = 1'b1;
        md_reg   = 5'd7;
        md_data  = 32'h1234_5678;
        tick();
        md_valid = 1'b0;
        tests_run++;
        if (ctrl_writeEnable !== 1'b1) begin tests_failed++; $display("FAIL byp_we: got %0b expected 1", ctrl_writeEnable); end
        tests_run++;
        if (ctrl_writeReg !== 5'd7) begin tests_failed++; $display("FAIL byp_reg: got %0d expected 7", ctrl_writeReg); end
        tests_run++;
        if (data_writeReg !== 32'h1234_5678) begin tests_failed++; $display("FAIL byp_data: got %08h expected 12345678", data_writeReg); end
        tests_run++;
        if (pending_mask !== 32'd0) begin tests_failed++; $display("FAIL byp_pending_clr: got %08h expected 0", pending_mask); end
        tests_run++;
        if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL byp_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_contention();
        wb_valid = 1'b1;
        wb_reg   = 5'd3;
        wb_data  = 32'h1;
        md_valid = 1'b1;
        md_reg   = 5'd9;
        md_data  = 32'h2;
        tick();
        set_idle();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h1) begin
            tests_failed++;
            $display("FAIL cont_first: got we=%0b reg=%0d data=%08h expected we=1 reg=3 data=1", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (fifo_count !== 2'd1) begin tests_failed++; $display("FAIL cont_count1: got %0d expected 1", fifo_count); end
        tick();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h2) begin
            tests_failed++;
            $display("FAIL cont_second: got we=%0b reg=%0d data=%08h expected we=1 reg=9 data=2", ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL cont_count0: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_full_drain();
        int k;
        int seen_reg[$];
        logic [31:0] seen_data[$];
        k = 0;
        for (int c = 0; c < 10; c++) begin
            wb_valid = (c < 5);
            wb_reg   = 5'(20 + c);
            wb_data  = 32'(c);
            md_valid = (k < 3);
            md_reg   = 5'(10 + k);
            md_data  = 32'hA0 + 32'(k);
            tick();
            if (exp_acc) k++;
            if (c == 1) begin
                tests_run++;
                if (md_ready !== 1'b0 || fifo_count !== 2'd2) begin
                    tests_failed++;
                    $display("FAIL full_ready: got ready=%0b count=%0d expected ready=0 count=2", md_ready, fifo_count);
                end
            end
            tests_run++;
            if (ctrl_writeEnable !== exp_we || (exp_we && ctrl_writeReg !== exp_reg)) begin
                tests_failed++;
                $display("FAIL full_write c%0d: got we=%0b reg=%0d expected we=%0b reg=%0d", c, ctrl_writeEnable, ctrl_writeReg, exp_we, exp_reg);
            end
            if (ctrl_writeEnable && ctrl_writeReg >= 5'd10 && ctrl_writeReg <= 5'd12) begin
                seen_reg.push_back(int'(ctrl_writeReg));
                seen_data.push_back(data_writeReg);
            end
        end
        set_idle();
        tests_run++;
        if (seen_reg.size() != 3) begin
            tests_failed++;
            $display("FAIL drain_count: got %0d md writes expected 3", seen_reg.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (seen_reg[i] != 10 + i || seen_data[i] !== 32'hA0 + 32'(i)) begin
                    tests_failed++;
                    $display("FAIL drain_order %0d: got reg=%0d data=%08h expected reg=%0d data=%08h", i, seen_reg[i], seen_data[i], 10 + i, 32'hA0 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        md_issue     = 1'b1;
        md_issue_reg = 5'd4;
        tick();
        md_issue_reg = 5'd5;
        tick();
        md_issue = 1'b0;
        wb_valid = 1'b1;
        wb_reg   = 5'd1;
        for (int c = 0; c < 2; c++) begin
            md_valid = 1'b1;
            md_reg   = 5'(4 + c);
            md_data  = 32'hB0 + 32'(c);
            tick();
        end
        tests_run++;
        if (fifo_count !== 2'd2 || pending_mask !== 32'h0000_0030) begin
            tests_failed++;
            $display("FAIL mid_setup: got count=%0d pending=%08h expected count=2 pending=00000030", fifo_count, pending_mask);
        end
        ctrl_reset = 1'b0;
        md_reg     = 5'd6;
        tick();
        tests_run++;
        if (fifo_count !== 2'd0 || pending_mask !== 32'd0 || ctrl_writeEnable !== 1'b0 || md_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: got count=%0d pending=%08h we=%0b ready=%0b expected 0 0 0 1", fifo_count, pending_mask, ctrl_writeEnable, md_ready);
        end
        set_idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin
                tests_failed++;
                $display("FAIL mid_stale c%0d: got we=%0b count=%0d expected we=0 count=0", c, ctrl_writeEnable, fifo_count);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ctrl_reset   = ($urandom_range(0, 99) != 0);
            wb_valid     = ($urandom_range(0, 1) == 1);
            wb_reg       = 5'($urandom_range(0, 31));
            wb_data      = $urandom;
            md_issue     = ($urandom_range(0, 3) == 0);
            md_issue_reg = 5'($urandom_range(0, 31));
            if (!md_valid && $urandom_range(0, 2) == 0) begin
                md_valid = 1'b1;
                md_reg   = 5'($urandom_range(0, 31));
                md_data  = $urandom;
            end
            tick();
            if (exp_acc || !ctrl_reset) md_valid = 1'b0;
            tests_run++;
            if (ctrl_writeEnable !== exp_we) begin tests_failed++; $display("FAIL rand_we c%0d: got %0b expected %0b", c, ctrl_writeEnable, exp_we); end
            if (exp_we) begin
                tests_run++;
                if (ctrl_writeReg !== exp_reg || data_writeReg !== exp_data) begin
                    tests_failed++;
                    $display("FAIL rand_write c%0d: got reg=%0d data=%08h expected reg=%0d data=%08h", c, ctrl_writeReg, data_writeReg, exp_reg, exp_data);
                end
            end
            tests_run++;
            if (pending_mask !== exp_pending) begin tests_failed++; $display("FAIL rand_pending c%0d: got %08h expected %08h", c, pending_mask, exp_pending); end
            tests_run++;
            if (fifo_count !== 2'(exp_q.size())) begin tests_failed++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, fifo_count, exp_q.size()); end
            tests_run++;
            if (md_ready !== (exp_q.size() < DEPTH)) begin tests_failed++; $display("FAIL rand_ready c%0d: got %0b expected %0b", c, md_ready, exp_q.size() < DEPTH); end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        ctrl_reset  = 1'b0;
        exp_pending = '0;
        exp_we      = 1'b0;
        exp_reg     = '0;
        exp_data    = '0;
        exp_acc     = 1'b0;
        test_reset();
        test_pipeline_write();
        test_bypass();
        test_contention();
        test_full_drain();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Initiator side of the register file write port: the only driver of ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- Merges two writeback sources into the single regfile write port:
  - the pipeline W stage, which has fixed priority and is never stalled;
  - the multi-cycle multdiv unit, which uses a valid/ready handshake.
- Buffers multdiv results in a small FIFO while the pipeline holds the port.
- Keeps a per-register pending scoreboard that the hazard/stall logic reads.

Parameters:
- DEPTH, 2, multdiv result FIFO depth in entries (1..3; count fits 2 bits).
- NUM_REGS, 32, number of architectural registers (width of pending_mask).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- ctrl_reset  in  1  synchronous reset, active-low.
- wb_valid  in  1  pipeline W stage requests a write this cycle; always accepted.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  32  pipeline write data.
- md_issue  in  1  multdiv op issued this cycle; marks md_issue_reg pending.
- md_issue_reg  in  5  destination of the issued multdiv op.
- md_valid  in  1  multdiv result valid.
- md_reg  in  5  multdiv result destination.
- md_data  in  32  multdiv result data.
- md_ready  out  1  arbiter can accept a multdiv result this cycle.
- ctrl_writeEnable  out  1  regfile write enable (registered).
- ctrl_writeReg  out  5  regfile write address (registered).
- data_writeReg  out  32  regfile write data (registered).
- pending_mask  out  32  bit i = 1 while register i awaits a multdiv writeback.
- fifo_count  out  2  current FIFO occupancy.

Behaviour:
- **Reset.** When ctrl_reset == 0 at a rising edge, the next state is:
  - ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0;
  - pending_mask = 0, FIFO empty, fifo_count = 0, md_ready = 1.
  - Reset overrides every simultaneous event. An in-flight multdiv result is dropped, and its pending bit is cleared.
- **Handshake.** md_ready = (fifo_count < DEPTH), combinational from state only. A result is accepted when md_valid && md_ready. The multdiv unit holds md_reg/md_data stable until it is accepted.
- **Write selection.** Each cycle at most one write is selected, in this priority order:
  1. wb_valid;
  2. FIFO head (when the FIFO is non-empty);
  3. the accepted md result, bypassed directly (only when the FIFO is empty).
- **Output register.** The selected write is loaded into the output register at the rising edge and presented to the regfile the following cycle. Pipeline-to-regfile latency is therefore exactly 1 cycle.
- **Enqueue rule.** An accepted md result that is not selected for bypass is enqueued. This happens when wb_valid = 1 or the FIFO is non-empty.
- **Simultaneous FIFO events.**
  - Enqueue and dequeue in the same cycle: fifo_count is unchanged and order is preserved.
  - Enqueue while full cannot occur, because md_ready = 0.
- **FIFO structure.** Circular buffer with head/tail pointers that wrap modulo DEPTH. FIFO entries store {reg, data}.
- **No-write cycle.** With no selection: ctrl_writeEnable = 0. ctrl_writeReg and data_writeReg hold their previous values.
- **Register 0 is never written.**
  - A selected write with reg == 0 is consumed (dequeued or accepted) but loads ctrl_writeEnable = 0.
  - md_issue with md_issue_reg == 0 sets no pending bit.
- **Pending scoreboard.**
  - Set: bit[md_issue_reg] is set on md_issue.
  - Clear: bit[r] is cleared at the edge where a multdiv write to r is loaded into the output register, either from the FIFO or bypassed.
  - Set and clear of the same bit in the same cycle: set wins.
  - A pipeline write to a pending register does not clear the bit.
- **Starvation.** Continuous wb_valid starves the FIFO. This is legal: the FIFO fills, md_ready drops, and multdiv stalls. Draining resumes in the first cycle with wb_valid = 0, at one entry per cycle.

Test Plan:
- **Reset.** Drive ctrl_reset = 0 for 2 cycles with random inputs toggling → all outputs 0, md_ready = 1, fifo_count = 0.
- **Pipeline write.** wb_valid = 1, wb_reg = 5, wb_data = 0xDEADBEEF → next cycle ctrl_writeEnable = 1, ctrl_writeReg = 5, data_writeReg = 0xDEADBEEF. Repeat with wb_reg = 0 → ctrl_writeEnable = 0.
- **Bypass with scoreboard.** md_issue to reg 7 → pending_mask = 0x80. Later md_valid to reg 7 with data 0x12345678, FIFO empty, wb idle → write appears 1 cycle later; pending_mask = 0 in the same cycle.
- **Contention.** wb_valid = 1 (reg 3, data 0x1) and md result (reg 9, data 0x2) in the same cycle → reg 3 written at t+1, reg 9 written at t+2; fifo_count is 1 at t+1, then 0.
- **Full FIFO and drain.** Hold wb_valid = 1 for 5 cycles while md_valid streams results to regs 10, 11, 12 → md_ready = 0 once fifo_count = 2. After wb drops: regs 10 and 11 are written in order, then 12 (accepted once space frees), with no loss or duplication.
- **Reset mid-operation.** Reset asserted with FIFO holding 2 entries and pending bits set → FIFO empty, pending_mask = 0; no stale write is issued after reset releases.
